// File: rtl/params_noc.sv
// Shared NoC types: port directions, flit labels and the flit record
// exchanged between router stages.
package params_noc;

    localparam int DEFAULT_BUFFER_SIZE    = 8;
    localparam int DEFAULT_ON_OFF_THRESH  = 2;
    localparam int X_ADDR_WIDTH           = 2;
    localparam int Y_ADDR_WIDTH           = 2;
    localparam int PAYLOAD_WIDTH          = 16;

    typedef enum logic [2:0] {
        LOCAL = 3'd0,
        NORTH = 3'd1,
        EAST  = 3'd2,
        SOUTH = 3'd3,
        WEST  = 3'd4
    } inout_Port;

    typedef enum logic [1:0] {
        HEAD     = 2'd0,
        BODY     = 2'd1,
        TAIL     = 2'd2,
        HEADTAIL = 2'd3
    } flit_label_t;

    typedef struct packed {
        flit_label_t              flit_label;
        logic [X_ADDR_WIDTH-1:0]  x_Dest;
        logic [Y_ADDR_WIDTH-1:0]  y_Dest;
        logic [PAYLOAD_WIDTH-1:0] payload;
    } flit_t;

    function automatic logic opens_packet(input flit_label_t lbl);
        return (lbl == HEAD) || (lbl == HEADTAIL);
    endfunction

    function automatic logic closes_packet(input flit_label_t lbl);
        return (lbl == TAIL) || (lbl == HEADTAIL);
    endfunction

endpackage

// File: rtl/circular_buffer.sv
// Circular flit FIFO with a combinational view of the head entry.
// Pushes into a full buffer are discarded; pops of an empty buffer are ignored.
module circular_buffer
    import params_noc::*;
#(
    parameter  int DEPTH = DEFAULT_BUFFER_SIZE,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int CNT_W = PTR_W + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push_i,
    input  logic             pop_i,
    input  flit_t            data_i,
    output flit_t            head_o,
    output logic [CNT_W-1:0] count_o,
    output logic             full_o,
    output logic             empty_o
);

    flit_t            mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             push_ok;
    logic             pop_ok;

    assign full_o  = (count_q == CNT_W'(DEPTH));
    assign empty_o = (count_q == '0);
    assign count_o = count_q;
    assign push_ok = push_i && !full_o;
    assign pop_ok  = pop_i && !empty_o;
    assign head_o  = empty_o ? '0 : mem_q[rd_ptr_q];

    // DEPTH is a power of two, so pointer increments wrap on their own.
    always_comb begin
        wr_ptr_d = wr_ptr_q + PTR_W'(push_ok);
        rd_ptr_d = rd_ptr_q + PTR_W'(pop_ok);
        count_d  = count_q + CNT_W'(push_ok) - CNT_W'(pop_ok);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem_q[wr_ptr_q] <= data_i;
        end
    end

endmodule

// File: rtl/input_buffer_unit.sv
// Router input port: buffers flits, routes each packet once at its head,
// then forwards it flit by flit on switch-allocator grants (wormhole).
module input_buffer_unit
    import params_noc::*;
#(
    parameter int BUFFER_SIZE   = DEFAULT_BUFFER_SIZE,
    parameter int X_ADDR_SIZE   = X_ADDR_WIDTH,
    parameter int Y_ADDR_SIZE   = Y_ADDR_WIDTH,
    parameter int ON_OFF_THRESH = DEFAULT_ON_OFF_THRESH
) (
    input  logic                   clk,
    input  logic                   rst,
    input  flit_t                  data_i,
    input  logic                   valid_i,
    output logic                   on_off_o,
    output logic [X_ADDR_SIZE-1:0] x_Des_o,
    output logic [Y_ADDR_SIZE-1:0] y_Des_o,
    input  inout_Port              port_i,
    output logic                   sa_req_o,
    output inout_Port              sa_port_o,
    input  logic                   sa_grant_i,
    output flit_t                  data_o,
    output logic                   valid_o,
    output logic                   error_o
);

    localparam int CNT_W = $clog2(BUFFER_SIZE) + 1;

    localparam logic [0:0] ST_IDLE   = 1'b0;
    localparam logic [0:0] ST_ACTIVE = 1'b1;

    logic [0:0]       state_q, state_d;
    inout_Port        route_q, route_d;
    logic             on_off_q, on_off_d;
    logic             pop;
    logic             depart;
    logic             discard;
    flit_t            head;
    logic [CNT_W-1:0] count;
    logic             full;
    logic             empty;

    circular_buffer #(
        .DEPTH(BUFFER_SIZE)
    ) u_fifo (
        .clk    (clk),
        .rst    (rst),
        .push_i (valid_i),
        .pop_i  (pop),
        .data_i (data_i),
        .head_o (head),
        .count_o(count),
        .full_o (full),
        .empty_o(empty)
    );

    always_comb begin
        state_d = state_q;
        route_d = route_q;
        pop     = 1'b0;
        depart  = 1'b0;
        discard = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (!empty) begin
                    if (opens_packet(head.flit_label)) begin
                        route_d = port_i;
                        state_d = ST_ACTIVE;
                    end else begin
                        // Body/tail with no open packet: upstream lost sync, drop it.
                        pop     = 1'b1;
                        discard = 1'b1;
                    end
                end
            end
            default: begin
                if (sa_grant_i && !empty) begin
                    pop    = 1'b1;
                    depart = 1'b1;
                    if (closes_packet(head.flit_label)) begin
                        state_d = ST_IDLE;
                    end
                end
            end
        endcase
    end

    // Uses the registered count, so the flag lags occupancy by one cycle.
    assign on_off_d = (BUFFER_SIZE - int'(count)) > ON_OFF_THRESH;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            route_q  <= LOCAL;
            on_off_q <= 1'b1;
        end else begin
            state_q  <= state_d;
            route_q  <= route_d;
            on_off_q <= on_off_d;
        end
    end

    assign on_off_o  = on_off_q;
    assign x_Des_o   = head.x_Dest;
    assign y_Des_o   = head.y_Dest;
    assign sa_req_o  = (state_q == ST_ACTIVE) && !empty;
    assign sa_port_o = route_q;
    assign valid_o   = depart;
    assign data_o    = depart ? head : '0;
    assign error_o   = discard;

endmodule

// File: tb/tb_input_buffer_unit.sv
// Bench for input_buffer_unit: a table of hand-derived cycles, directed
// corner-case sequences, then random traffic against a queue-based model.
module tb_input_buffer_unit;
    import params_noc::*;

    localparam int DEPTH  = 8;
    localparam int THRESH = 2;

    logic      clk;
    logic      rst;
    flit_t     data_i;
    logic      valid_i;
    logic      on_off_o;
    logic [1:0] x_Des_o;
    logic [1:0] y_Des_o;
    inout_Port port_i;
    logic      sa_req_o;
    inout_Port sa_port_o;
    logic      sa_grant_i;
    flit_t     data_o;
    logic      valid_o;
    logic      error_o;

    input_buffer_unit #(
        .BUFFER_SIZE(DEPTH), .X_ADDR_SIZE(2), .Y_ADDR_SIZE(2), .ON_OFF_THRESH(THRESH)
    ) dut (
        .clk(clk), .rst(rst), .data_i(data_i), .valid_i(valid_i),
        .on_off_o(on_off_o), .x_Des_o(x_Des_o), .y_Des_o(y_Des_o),
        .port_i(port_i), .sa_req_o(sa_req_o), .sa_port_o(sa_port_o),
        .sa_grant_i(sa_grant_i), .data_o(data_o), .valid_o(valid_o),
        .error_o(error_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_vec = 0;
    int n_bad = 0;

    // Behavioural model: a packet is "open" between an accepted head and its tail.
    flit_t     mq[$];
    flit_t     log_q[$];
    bit        m_open;
    inout_Port m_route;
    bit        m_onoff;

    // Last sampled DUT outputs.
    logic      s_req, s_valid, s_err, s_onoff;
    inout_Port s_port;
    flit_t     s_data;
    logic [1:0] s_x, s_y;

    typedef struct {
        logic      vin;
        flit_t     din;
        inout_Port port;
        logic      grant;
        logic      exp_req;
        inout_Port exp_port;
        logic      exp_valid;
        flit_t     exp_data;
        logic      exp_err;
        logic      exp_onoff;
        logic [1:0] exp_x;
        logic [1:0] exp_y;
    } vec_t;

    vec_t tbl[7];

    function automatic flit_t mk(input flit_label_t l, input int x, input int y, input int pl);
        flit_t f;
        f.flit_label = l;
        f.x_Dest     = X_ADDR_WIDTH'(x);
        f.y_Dest     = Y_ADDR_WIDTH'(y);
        f.payload    = PAYLOAD_WIDTH'(pl);
        return f;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        mq.delete();
        m_open  = 0;
        m_route = LOCAL;
        m_onoff = 1;
    endtask

    // One clock cycle: drive on the falling edge, compare, then advance the model.
    task automatic step(input logic vin, input flit_t din, input inout_Port p, input logic g);
        bit    m_empty, e_valid, e_err, e_req;
        flit_t m_head, popped;
        int    sz;
        @(negedge clk);
        valid_i    = vin;
        data_i     = din;
        port_i     = p;
        sa_grant_i = g;
        #1;
        s_req = sa_req_o; s_valid = valid_o; s_err = error_o; s_onoff = on_off_o;
        s_port = sa_port_o; s_data = data_o; s_x = x_Des_o; s_y = y_Des_o;

        sz      = mq.size();
        m_empty = (sz == 0);
        m_head  = m_empty ? flit_t'('0) : mq[0];
        e_req   = m_open && !m_empty;
        e_valid = e_req && g;
        e_err   = !m_open && !m_empty && !opens_packet(m_head.flit_label);

        chk("sa_req", 32'(s_req), 32'(e_req));
        chk("sa_port", 32'(s_port), 32'(m_route));
        chk("valid_o", 32'(s_valid), 32'(e_valid));
        chk("data_o", 32'(s_data), e_valid ? 32'(m_head) : 32'd0);
        chk("error_o", 32'(s_err), 32'(e_err));
        chk("on_off", 32'(s_onoff), 32'(m_onoff));
        chk("x_des", 32'(s_x), 32'(m_head.x_Dest));
        chk("y_des", 32'(s_y), 32'(m_head.y_Dest));

        if (s_valid === 1'b1) begin
            log_q.push_back(s_data);
            $display("t=%0t out %s x=%0d y=%0d payload=%h port=%s",
                     $time, s_data.flit_label.name(), s_data.x_Dest, s_data.y_Dest,
                     s_data.payload, s_port.name());
        end

        @(posedge clk);
        if (!m_open && !m_empty && opens_packet(m_head.flit_label)) begin
            m_open  = 1;
            m_route = p;
        end else if (e_valid || e_err) begin
            popped = mq.pop_front();
            if (e_valid && closes_packet(popped.flit_label)) m_open = 0;
        end
        if (vin && sz < DEPTH) mq.push_back(din);
        m_onoff = (DEPTH - sz) > THRESH;
    endtask

    initial begin
        flit_t zf, ht, bd;
        flit_t pkt[4];
        zf = '0;
        ht = mk(HEADTAIL, 2, 1, 16'hA1);
        bd = mk(BODY, 3, 2, 16'hB2);
        //         vin  din port   g     req  sport valid data err  onoff x     y
        tbl[0] = '{1'b1, ht, LOCAL, 1'b1, 1'b0, LOCAL, 1'b0, zf, 1'b0, 1'b1, 2'd0, 2'd0};
        tbl[1] = '{1'b0, zf, EAST,  1'b1, 1'b0, LOCAL, 1'b0, zf, 1'b0, 1'b1, 2'd2, 2'd1};
        tbl[2] = '{1'b0, zf, WEST,  1'b1, 1'b1, EAST,  1'b1, ht, 1'b0, 1'b1, 2'd2, 2'd1};
        tbl[3] = '{1'b0, zf, LOCAL, 1'b1, 1'b0, EAST,  1'b0, zf, 1'b0, 1'b1, 2'd0, 2'd0};
        tbl[4] = '{1'b1, bd, NORTH, 1'b0, 1'b0, EAST,  1'b0, zf, 1'b0, 1'b1, 2'd0, 2'd0};
        tbl[5] = '{1'b0, zf, LOCAL, 1'b1, 1'b0, EAST,  1'b0, zf, 1'b1, 1'b1, 2'd3, 2'd2};
        tbl[6] = '{1'b0, zf, LOCAL, 1'b0, 1'b0, EAST,  1'b0, zf, 1'b0, 1'b1, 2'd0, 2'd0};

        rst = 1'b1; valid_i = 1'b0; data_i = '0; port_i = LOCAL; sa_grant_i = 1'b0;
        model_reset();
        #12;
        chk("rst_on_off", 32'(on_off_o), 32'd1);
        chk("rst_sa_req", 32'(sa_req_o), 32'd0);
        chk("rst_sa_port", 32'(sa_port_o), 32'(LOCAL));
        chk("rst_valid", 32'(valid_o), 32'd0);
        chk("rst_data", 32'(data_o), 32'd0);
        chk("rst_error", 32'(error_o), 32'd0);
        @(negedge clk);
        rst = 1'b0;

        // Single HEADTAIL, then an orphan BODY.
        for (int i = 0; i < 7; i++) begin
            step(tbl[i].vin, tbl[i].din, tbl[i].port, tbl[i].grant);
            chk("tbl_req", 32'(s_req), 32'(tbl[i].exp_req));
            chk("tbl_port", 32'(s_port), 32'(tbl[i].exp_port));
            chk("tbl_valid", 32'(s_valid), 32'(tbl[i].exp_valid));
            chk("tbl_data", 32'(s_data), 32'(tbl[i].exp_data));
            chk("tbl_err", 32'(s_err), 32'(tbl[i].exp_err));
            chk("tbl_onoff", 32'(s_onoff), 32'(tbl[i].exp_onoff));
            chk("tbl_x", 32'(s_x), 32'(tbl[i].exp_x));
            chk("tbl_y", 32'(s_y), 32'(tbl[i].exp_y));
        end

        // Four-flit packet, toggling grant, port_i moving after the head is routed.
        pkt[0] = mk(HEAD, 1, 3, 16'h10);
        pkt[1] = mk(BODY, 1, 3, 16'h11);
        pkt[2] = mk(BODY, 1, 3, 16'h12);
        pkt[3] = mk(TAIL, 1, 3, 16'h13);
        log_q.delete();
        for (int i = 0; i < 12; i++) begin
            step(i < 4, (i < 4) ? pkt[i] : zf, (i == 1) ? EAST : inout_Port'(3'(i % 5)),
                 (i % 2) == 0);
            if (i > 1 && s_req === 1'b1) chk("pkt4_port_held", 32'(s_port), 32'(EAST));
        end
        chk("pkt4_count", 32'(log_q.size()), 32'd4);
        for (int i = 0; i < 4; i++)
            chk("pkt4_order", (i < log_q.size()) ? 32'(log_q[i].payload) : 32'hFFFF_FFFF,
                32'(pkt[i].payload));

        // Ten pushes into an 8-deep buffer with no grant.
        for (int i = 0; i < 10; i++) begin
            step(1'b1, mk((i == 0) ? HEAD : ((i == 9) ? TAIL : BODY), 3, 0, 16'h20 + i),
                 SOUTH, 1'b0);
            chk("fill_onoff", 32'(s_onoff), (i <= 6) ? 32'd1 : 32'd0);
        end
        // Push while full alongside a pop: push lost, seven flits remain.
        log_q.delete();
        step(1'b1, mk(BODY, 0, 0, 16'hEE), WEST, 1'b1);
        for (int i = 0; i < 10; i++) step(1'b0, zf, LOCAL, 1'b1);
        chk("full_drain_count", 32'(log_q.size()), 32'd8);
        for (int i = 0; i < 8; i++)
            chk("full_drain_order", (i < log_q.size()) ? 32'(log_q[i].payload) : 32'hFFFF_FFFF,
                32'h20 + 32'(i));

        // Asynchronous reset with a packet still open and flits buffered.
        step(1'b1, mk(BODY, 1, 1, 16'h31), LOCAL, 1'b0);
        step(1'b1, mk(BODY, 1, 1, 16'h32), LOCAL, 1'b0);
        @(negedge clk);
        valid_i = 1'b0; sa_grant_i = 1'b0;
        #3 rst = 1'b1;
        #1;
        chk("arst_sa_req", 32'(sa_req_o), 32'd0);
        chk("arst_sa_port", 32'(sa_port_o), 32'(LOCAL));
        chk("arst_on_off", 32'(on_off_o), 32'd1);
        chk("arst_x", 32'(x_Des_o), 32'd0);
        chk("arst_y", 32'(y_Des_o), 32'd0);
        chk("arst_error", 32'(error_o), 32'd0);
        model_reset();
        @(negedge clk);
        rst = 1'b0;
        log_q.delete();
        step(1'b1, mk(HEADTAIL, 0, 2, 16'h40), LOCAL, 1'b1);
        step(1'b0, zf, NORTH, 1'b1);
        step(1'b0, zf, LOCAL, 1'b1);
        step(1'b0, zf, LOCAL, 1'b1);
        chk("post_rst_count", 32'(log_q.size()), 32'd1);
        chk("post_rst_flit", (log_q.size() > 0) ? 32'(log_q[0].payload) : 32'hFFFF_FFFF,
            32'h40);

        // Random traffic against the model.
        for (int i = 0; i < 1500; i++) begin
            step($urandom_range(0, 1) == 1,
                 mk(flit_label_t'($urandom_range(0, 3)), $urandom_range(0, 3),
                    $urandom_range(0, 3), $urandom_range(0, 16'hFFFF)),
                 inout_Port'($urandom_range(0, 4)),
                 $urandom_range(0, 9) < 6);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
